// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port (fetch/data) arbiter onto a single-cycle shared memory; optional MEM_ARB_RR_EN selects round-robin
module mem_arb #(
    parameter logic [31:0] MEMSIZE = 32'h20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
    localparam logic [31:0] LAST_ADDR = MEMSIZE - 32'd4;

    state_t      state_q, state_d;
    logic        own_q, own_d;          // 1 = data port owns the transaction
    logic        wr_q, wr_d;
    logic        oor_q, oor_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_err_q, i_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;
    logic        sel_d;
    logic        can_accept;
    logic [31:0] sel_addr;
    logic [31:0] resp_data;

`ifdef MEM_ARB_RR_EN
    logic        last_q, last_d;        // 1 = data port served last

    // Round-robin: on a tie the port that was not served last wins.
    always_comb begin
        sel_d = d_req && (!i_req || !last_q);
    end
`else
    // Fixed priority: the data port always wins a tie.
    always_comb begin
        sel_d = d_req;
    end
`endif

    // Grants are only offered outside ACCESS and are suppressed while in reset.
    always_comb begin
        can_accept = rst_n && (state_q != ACCESS);
        d_gnt      = can_accept && sel_d;
        i_gnt      = can_accept && i_req && !sel_d;
        sel_addr   = d_gnt ? d_addr : i_addr;
        resp_data  = oor_q ? ERR_DATA : (wr_q ? 32'h0 : mem_data_out);
    end

    // Next-state logic: latch the winning request, then capture the response.
    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        wr_d      = wr_q;
        oor_d     = oor_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        i_err_d   = i_err_q;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            ACCESS: begin
                state_d = RESP;
                if (own_q) begin
                    d_rdata_d = resp_data;
                    d_err_d   = oor_q;
                end else begin
                    i_rdata_d = resp_data;
                    i_err_d   = oor_q;
                end
            end
            default: begin
                if (i_gnt || d_gnt) begin
                    state_d = ACCESS;
                    own_d   = d_gnt;
                    wr_d    = d_gnt && d_wr;
                    addr_d  = sel_addr;
                    wdata_d = d_gnt ? d_wdata : 32'h0;
                    oor_d   = sel_addr > LAST_ADDR;
`ifdef MEM_ARB_RR_EN
                    last_d  = d_gnt;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            wr_q      <= 1'b0;
            oor_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            i_rdata_q <= 32'h0;
            i_err_q   <= 1'b0;
            d_rdata_q <= 32'h0;
            d_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            wr_q      <= wr_d;
            oor_q     <= oor_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            i_err_q   <= i_err_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    // Memory strobes and completion pulses decode directly from the state.
    always_comb begin
        mem_enable  = (state_q == ACCESS) && !oor_q;
        mem_wr      = mem_enable && wr_q && own_q;
        mem_addr    = addr_q;
        mem_data_in = wdata_q;
        i_valid     = (state_q == RESP) && !own_q;
        d_valid     = (state_q == RESP) && own_q;
        i_rdata     = i_rdata_q;
        i_err       = i_err_q;
        d_rdata     = d_rdata_q;
        d_err       = d_err_q;
        busy        = (state_q != IDLE);
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL provide parameter MEMSIZE, default 32'h20000, byte size of the shared memory; an access with addr > MEMSIZE-4 is out-of-range.
REQ-002 SHALL provide ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_req  in  1  instruction-fetch read request; i_addr  in  32  fetch byte address.
REQ-005 i_gnt  out  1  fetch request accepted this cycle; i_valid  out  1  one-cycle fetch completion pulse; i_rdata  out  32  fetch data; i_err  out  1  out-of-range flag, valid with i_valid.
REQ-006 d_req  in  1  data request; d_wr  in  1  1=write, 0=read; d_addr  in  32  byte address; d_wdata  in  32  write data.
REQ-007 d_gnt  out  1  data request accepted; d_valid  out  1  one-cycle data completion pulse; d_rdata  out  32  read data; d_err  out  1  out-of-range flag.
REQ-008 mem_enable, mem_wr  out  1 each, mem_addr, mem_data_in  out  32 each  to the single-cycle memory; mem_data_out  in  32  combinational read data from memory.
REQ-009 busy  out  1  high when state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, ACCESS, RESP.
REQ-011 Acceptance SHALL occur only in IDLE or RESP: when at least one req is high, exactly one gnt is driven high combinationally in that cycle; gnt is 0 in ACCESS.
REQ-012 On an accepted request the block SHALL latch port id, wr, addr and wdata at the clock edge and enter ACCESS; with no accepted request IDLE stays IDLE and RESP returns to IDLE.
REQ-013 In ACCESS, mem_enable SHALL be 1, and mem_wr/mem_addr/mem_data_in SHALL be the latched values; in IDLE and RESP, mem_enable and mem_wr SHALL be 0.
REQ-014 At the ACCESS->RESP edge, read data SHALL be captured from mem_data_out into the owning port's rdata register; for writes, rdata SHALL be captured as 32'h0.
REQ-015 In RESP, exactly the owning port's valid SHALL be 1 for one cycle; the other port's rdata is unchanged.
REQ-016 Latency SHALL be accept edge + 2 cycles to valid; peak throughput one access per 2 cycles (accept in RESP allowed).
REQ-017 Out-of-range requests (addr > MEMSIZE-4) SHALL still be granted and pass through ACCESS with mem_enable forced 0; in RESP, err=1 and rdata=32'hDEADBEEF.
REQ-018 The fetch port SHALL never assert mem_wr.
REQ-019 Requesters SHALL hold req and payload stable until gnt; a req dropped before gnt is ignored without error.
REQ-020 A port's rdata/err SHALL hold until that port's next valid.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, all gnt/valid/err/mem_enable/mem_wr 0, mem_addr/mem_data_in/rdata 0, arbitration pointer to "fetch last served".
REQ-022 Reset during ACCESS or RESP SHALL abort the transaction with no valid pulse ever issued for it.
REQ-023 First grant SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: round-robin -- on simultaneous requests, the port not served last is granted; pointer updates on every grant.
REQ-025 MEM_ARB_RR_EN undefined: fixed priority -- data port always wins simultaneous requests; no pointer state.

Verification
REQ-026 Reset, i_req=1 i_addr=0x100, mem holds 0x11223344 at 0x100 -> i_gnt cycle 0, mem_enable cycle 1, i_valid=1 i_rdata=0x11223344 cycle 2.
REQ-027 d_req=1 d_wr=1 d_addr=0x40 d_wdata=0xCAFEF00D, then d read 0x40 -> write: mem_wr=1 in ACCESS, d_valid with d_rdata=0; read: d_rdata=0xCAFEF00D.
REQ-028 i_req and d_req held high for 8 accesses -> RR_EN: grants alternate d,i,d,i... (pointer reset to fetch => data first); no RR_EN: all 8 grants to data, fetch starved.
REQ-029 d_addr=0x1FFFD read -> mem_enable stays 0, d_valid=1 d_err=1 d_rdata=0xDEADBEEF; next request at 0x1FFFC -> d_err=0.
REQ-030 rst_n pulsed low during ACCESS of a write to 0x80 -> outputs 0 asynchronously, no valid, memory at 0x80 unchanged.
